// File: rtl/pq_ntt_pkg.sv
// Shared NTT control types: FSM state encoding, ring-dimension decode, twiddle index base.
package pq_ntt_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_BFLY,
    ST_UPD,
    ST_FIN
  } ntt_state_e;

  localparam logic [3:0] INDEX_BASE = 4'd10;

  // Unsupported ring dimensions fall back to n = 256.
  function automatic logic [3:0] log2_n(input logic [10:0] n);
    case (n)
      11'h200: return 4'd9;
      11'h400: return 4'd10;
      default: return 4'd8;
    endcase
  endfunction

endpackage

// File: rtl/ntt_stage_ctrl.sv
// Cooley-Tukey NTT address/twiddle sequencer: one butterfly pair per bf_valid&bf_ready handshake.
// All outputs registered; a stalled request holds its addresses until bf_ready.
module ntt_stage_ctrl
  import pq_ntt_pkg::*;
#(
  parameter int ADDR_WIDTH = 10
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic                  abort,
  input  logic [10:0]           param_n,
  input  logic                  fwd_ntt_i,
  input  logic                  bf_ready,
  output logic                  bf_valid,
  output logic [ADDR_WIDTH-1:0] addr_a,
  output logic [ADDR_WIDTH-1:0] addr_b,
  output logic                  update_m,
  output logic                  update_omega,
  output logic [3:0]            index,
  output logic                  fwd_ntt,
  output logic                  busy,
  output logic                  done
);

  localparam int CW = ADDR_WIDTH + 1;
  localparam logic [ADDR_WIDTH-1:0] ONE_AW = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [CW-1:0]         ONE_CW = {{(CW-1){1'b0}}, 1'b1};

  ntt_state_e            state_q;
  logic [3:0]            s_q, l_q, index_q;
  logic [ADDR_WIDTH-1:0] j_q, k_q, addr_a_q, addr_b_q;
  logic                  bf_valid_q, update_m_q, update_omega_q, fwd_q, busy_q, done_q;

  logic [ADDR_WIDTH-1:0] half_w, cur_a, nxt_a;
  logic [CW-1:0]         m_w, n_w, k_d;
  logic                  hs, inner_end, j_last, s_last;

  // k_d is one bit wider than k_q so the group-base overflow past n is visible.
  assign half_w    = ONE_AW << s_q;
  assign m_w       = {half_w, 1'b0};
  assign n_w       = ONE_CW << l_q;
  assign k_d       = {1'b0, k_q} + m_w;
  assign inner_end = (k_d >= n_w);
  assign j_last    = (j_q == half_w - ONE_AW);
  assign s_last    = (s_q == l_q - 4'd1);
  assign cur_a     = k_q + j_q;
  assign nxt_a     = k_d[ADDR_WIDTH-1:0] + j_q;
  assign hs        = bf_valid_q & bf_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= ST_IDLE;
      s_q            <= '0;
      l_q            <= '0;
      j_q            <= '0;
      k_q            <= '0;
      index_q        <= '0;
      addr_a_q       <= '0;
      addr_b_q       <= '0;
      bf_valid_q     <= 1'b0;
      update_m_q     <= 1'b0;
      update_omega_q <= 1'b0;
      fwd_q          <= 1'b0;
      busy_q         <= 1'b0;
      done_q         <= 1'b0;
    end else begin
      update_m_q     <= 1'b0;
      update_omega_q <= 1'b0;
      done_q         <= 1'b0;
      if (abort && state_q != ST_IDLE) begin
        state_q    <= ST_IDLE;
        busy_q     <= 1'b0;
        bf_valid_q <= 1'b0;
        index_q    <= '0;
        s_q        <= '0;
        j_q        <= '0;
        k_q        <= '0;
      end else begin
        case (state_q)
          ST_IDLE: if (start) begin
            l_q        <= log2_n(param_n);
            fwd_q      <= fwd_ntt_i;
            s_q        <= '0;
            j_q        <= '0;
            k_q        <= '0;
            index_q    <= INDEX_BASE;
            update_m_q <= 1'b1;
            busy_q     <= 1'b1;
            state_q    <= ST_LOAD;
          end
          ST_LOAD, ST_UPD: begin
            bf_valid_q <= 1'b1;
            addr_a_q   <= cur_a;
            addr_b_q   <= cur_a + half_w;
            state_q    <= ST_BFLY;
          end
          ST_BFLY: if (hs) begin
            if (!inner_end) begin
              k_q      <= k_d[ADDR_WIDTH-1:0];
              addr_a_q <= nxt_a;
              addr_b_q <= nxt_a + half_w;
            end else if (!j_last) begin
              j_q            <= j_q + ONE_AW;
              k_q            <= '0;
              bf_valid_q     <= 1'b0;
              update_omega_q <= 1'b1;
              state_q        <= ST_UPD;
            end else if (!s_last) begin
              s_q        <= s_q + 4'd1;
              j_q        <= '0;
              k_q        <= '0;
              bf_valid_q <= 1'b0;
              update_m_q <= 1'b1;
              index_q    <= INDEX_BASE - (s_q + 4'd1);
              state_q    <= ST_LOAD;
            end else begin
              bf_valid_q <= 1'b0;
              done_q     <= 1'b1;
              state_q    <= ST_FIN;
            end
          end
          ST_FIN: begin
            busy_q  <= 1'b0;
            index_q <= '0;
            s_q     <= '0;
            j_q     <= '0;
            k_q     <= '0;
            state_q <= ST_IDLE;
          end
          default: state_q <= ST_IDLE;
        endcase
      end
    end
  end

  assign bf_valid     = bf_valid_q;
  assign addr_a       = addr_a_q;
  assign addr_b       = addr_b_q;
  assign update_m     = update_m_q;
  assign update_omega = update_omega_q;
  assign index        = index_q;
  assign fwd_ntt      = fwd_q;
  assign busy         = busy_q;
  assign done         = done_q;

endmodule

// File: doc/ntt_stage_ctrl.md
NTT_STAGE_CTRL -- requirements
Module: ntt_stage_ctrl

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 10, meaning coefficient address width (n up to 1024).
REQ-002 SHALL have port clk  input  1  rising-edge clock.
REQ-003 SHALL have port rst_n  input  1  reset; asynchronous, active-low.
REQ-004 SHALL have port start  input  1  single-cycle request to begin one transform.
REQ-005 SHALL have port abort  input  1  synchronous cancel of a running transform.
REQ-006 SHALL have port param_n  input  11  ring dimension: 11'h100, 11'h200 or 11'h400.
REQ-007 SHALL have port fwd_ntt_i  input  1  1 = forward NTT, 0 = inverse.
REQ-008 SHALL have port bf_ready  input  1  butterfly datapath accepts the current address pair.
REQ-009 SHALL have port bf_valid  output  1  addr_a/addr_b hold a valid butterfly request.
REQ-010 SHALL have port addr_a  output  ADDR_WIDTH  upper butterfly operand address.
REQ-011 SHALL have port addr_b  output  ADDR_WIDTH  lower operand address (addr_a + half).
REQ-012 SHALL have port update_m  output  1  stage-start twiddle reload pulse.
REQ-013 SHALL have port update_omega  output  1  twiddle advance pulse (omega := omega*omega_m).
REQ-014 SHALL have port index  output  4  twiddle table index for the current stage.
REQ-015 SHALL have port fwd_ntt  output  1  direction latched at start.
REQ-016 SHALL have ports busy, done  output  1 each  transform running; one-cycle completion pulse.

Function
REQ-017 SHALL decode L = log2(n): 8, 9, 10 for 11'h100, 11'h200, 11'h400; any other value treated as 11'h100.
REQ-018 SHALL run stages s = 0..L-1 with half = 2^s, m = 2^(s+1); loop order j = 0..half-1 outer, group base k = 0, m, 2m, ... < n inner; addr_a = k+j, addr_b = k+j+half.
REQ-019 SHALL implement states IDLE, LOAD, BFLY, UPD, FIN; IDLE->LOAD on start; LOAD->BFLY after one cycle; BFLY->UPD when inner loop ends and j < half-1; BFLY->LOAD when j = half-1 and s < L-1; BFLY->FIN when last butterfly of stage L-1 handshakes; UPD->BFLY after one cycle; FIN->IDLE after one cycle.
REQ-020 SHALL assert update_m for exactly the one LOAD cycle and update_omega for exactly the one UPD cycle; both never together.
REQ-021 SHALL drive index = 10 - s, constant through LOAD, BFLY and UPD of stage s.
REQ-022 SHALL assert bf_valid only in BFLY; a handshake is bf_valid & bf_ready; addresses SHALL stay stable while bf_valid & !bf_ready.
REQ-023 SHALL advance counters only on handshake; transitions at loop ends occur on the final handshake's edge.
REQ-024 SHALL latch fwd_ntt_i and L at start; changes on param_n/fwd_ntt_i while busy SHALL be ignored.
REQ-025 SHALL ignore start while busy; busy = 1 in every state except IDLE.
REQ-026 SHALL pulse done in FIN only; done and bf_valid never together.
REQ-027 SHALL, on abort in any non-IDLE state, go to IDLE next cycle with no done pulse; abort has priority over start and handshake; abort in IDLE has no effect.
REQ-028 SHALL produce, with bf_ready tied high, exactly L*(n/2) handshakes, L update_m pulses and (n-1-L) update_omega pulses per transform.

Reset
REQ-029 SHALL on rst_n low asynchronously enter IDLE with bf_valid, update_m, update_omega, busy, done = 0, addr_a, addr_b, index = 0, fwd_ntt = 0, all counters 0.
REQ-030 SHALL discard a transform in progress on reset; first action after reset release is waiting for start.

Structure
REQ-031 SHALL place the state enum, log2 decode function and constant INDEX_BASE = 10 in shared package pq_ntt_pkg.
REQ-032 SHALL be a single FSM with s/j/k counters; no sub-module is required.

Verification
REQ-033 SHALL check n=256, fwd, bf_ready=1: first pairs (0,1),(2,3); stage 0 has 128 handshakes, no update_omega; index 10 then 9.
REQ-034 SHALL check n=256 stage 1: pairs (0,2),(4,6).. 64 handshakes, one update_omega pulse, then (1,3); totals 1024 handshakes, 8 update_m, 247 update_omega, one done.
REQ-035 SHALL check n=1024, inverse: 5120 handshakes, 10 update_m, 1013 update_omega, index 10..1, fwd_ntt = 0.
REQ-036 SHALL check random bf_ready stalls: addresses stable while stalled, sequence identical to unstalled run.
REQ-037 SHALL check abort at handshake 300 -> IDLE next cycle, no done; start during busy ignored; rst_n low mid-stage -> all outputs 0 immediately.
